pe_conv_cell: RTL and testbench



---
 rtl/pe_conv_cell.sv | 184 ++++++++++++++++++
 tb/tb_pe_conv_cell.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_cell.sv
// pe_conv_cell: one convolution PE. It captures taps and pixels, runs a 3-tap signed row MAC,
// and emits the result on a valid/ready port after ROWS rows. Optional macro PE_SAT_EN saturates the result.
module pe_conv_cell #(
    parameter int ROWS  = 3,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [7:0]       dataIn,
    input  logic             peRead,
    input  logic             peStart,
    input  logic [2:0]       filtSel,
    input  logic             resReady,
    output logic             resValid,
    output logic [OUT_W-1:0] result,
    output logic             busy,
    output logic             startDrop
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic signed [7:0]  w_r      [3];
    logic        [7:0]  win_r    [3];
    logic signed [7:0]  op_w_r   [3];
    logic        [7:0]  op_win_r [3];
    logic signed [23:0] acc_r, acc_nxt_s;
    logic        [3:0]  row_cnt_r;
    logic signed [8:0]  pix_s;
    logic signed [7:0]  wgt_s;
    logic signed [16:0] prod_s;
    logic               last_row_s;
    logic               hs_s;
    logic               valid_nxt_s, busy_nxt_s, drop_nxt_s;
    logic [OUT_W-1:0]   result_nxt_s;

    // Result formatting: clamp to the signed OUT_W range, or plain wrap-around truncation.
    function automatic logic [OUT_W-1:0] fmt(input logic signed [23:0] a);
`ifdef PE_SAT_EN
        logic signed [23:0] hi;
        logic signed [23:0] lo;
        hi = (24'sd1 <<< (OUT_W - 1)) - 24'sd1;
        lo = -(24'sd1 <<< (OUT_W - 1));
        if (a > hi) begin
            fmt = hi[OUT_W-1:0];
        end else if (a < lo) begin
            fmt = lo[OUT_W-1:0];
        end else begin
            fmt = a[OUT_W-1:0];
        end
`else
        fmt = a[OUT_W-1:0];
`endif
    endfunction

    assign last_row_s = (row_cnt_r == 4'(ROWS - 1));
    assign hs_s       = (state_r == OUT) && resReady;

    // Operand select for the current MAC tap; pixels are zero-extended so they stay unsigned.
    always_comb begin
        pix_s = 9'sd0;
        wgt_s = 8'sd0;
        case (state_r)
            MAC0: begin pix_s = $signed({1'b0, op_win_r[0]}); wgt_s = op_w_r[0]; end
            MAC1: begin pix_s = $signed({1'b0, op_win_r[1]}); wgt_s = op_w_r[1]; end
            MAC2: begin pix_s = $signed({1'b0, op_win_r[2]}); wgt_s = op_w_r[2]; end
            default: begin pix_s = 9'sd0; wgt_s = 8'sd0; end
        endcase
    end

    assign prod_s = pix_s * wgt_s;

    // Next-state and next-accumulator decode.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        case (state_r)
            IDLE: begin
                if (peStart) state_nxt_s = MAC0;
                else         state_nxt_s = IDLE;
            end
            MAC0: begin
                acc_nxt_s   = acc_r + {{7{prod_s[16]}}, prod_s};
                state_nxt_s = MAC1;
            end
            MAC1: begin
                acc_nxt_s   = acc_r + {{7{prod_s[16]}}, prod_s};
                state_nxt_s = MAC2;
            end
            MAC2: begin
                acc_nxt_s = acc_r + {{7{prod_s[16]}}, prod_s};
                if (last_row_s) state_nxt_s = OUT;
                else            state_nxt_s = IDLE;
            end
            OUT: begin
                if (hs_s) begin
                    acc_nxt_s   = 24'sd0;
                    state_nxt_s = IDLE;
                end else begin
                    acc_nxt_s   = acc_r;
                    state_nxt_s = OUT;
                end
            end
            default: begin
                acc_nxt_s   = 24'sd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode computed from the next state so the registered outputs line up with it.
    always_comb begin
        valid_nxt_s  = (state_nxt_s == OUT);
        busy_nxt_s   = (state_nxt_s != IDLE);
        drop_nxt_s   = peStart && (state_r != IDLE);
        if (state_nxt_s == OUT) result_nxt_s = fmt(acc_nxt_s);
        else                    result_nxt_s = '0;
    end

    // Control state, accumulator, row counter and operand snapshot.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            acc_r     <= 24'sd0;
            row_cnt_r <= 4'd0;
            for (int k = 0; k < 3; k++) begin
                op_w_r[k]   <= 8'sd0;
                op_win_r[k] <= 8'd0;
            end
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            if (state_r == MAC2)  row_cnt_r <= row_cnt_r + 4'd1;
            else if (hs_s)        row_cnt_r <= 4'd0;
            if ((state_r == IDLE) && peStart) begin
                for (int k = 0; k < 3; k++) begin
                    op_w_r[k]   <= w_r[k];
                    op_win_r[k] <= win_r[k];
                end
            end
        end
    end

    // Weight loads and pixel window shifts, accepted in every state.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 3; k++) begin
                w_r[k]   <= 8'sd0;
                win_r[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (filtSel[k]) w_r[k] <= $signed(dataIn);
            end
            if (peRead) begin
                win_r[2] <= win_r[1];
                win_r[1] <= win_r[0];
                win_r[0] <= dataIn;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            resValid  <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            startDrop <= 1'b0;
        end else begin
            resValid  <= valid_nxt_s;
            result    <= result_nxt_s;
            busy      <= busy_nxt_s;
            startDrop <= drop_nxt_s;
        end
    end

endmodule

// File: tb/tb_pe_conv_cell.sv
// Testbench for pe_conv_cell: directed steps plus random traffic, checked every cycle
// against a row-sum reference model.
module tb_pe_conv_cell;

    localparam int ROWS  = 3;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic [7:0]       dataIn = 8'd0;
    logic             peRead = 1'b0;
    logic             peStart = 1'b0;
    logic [2:0]       filtSel = 3'd0;
    logic             resReady = 1'b0;
    logic             resValid;
    logic [OUT_W-1:0] result;
    logic             busy;
    logic             startDrop;

    pe_conv_cell #(.ROWS(ROWS), .OUT_W(OUT_W)) dut (
        .clk(clk), .RST(RST), .dataIn(dataIn), .peRead(peRead), .peStart(peStart),
        .filtSel(filtSel), .resReady(resReady), .resValid(resValid), .result(result),
        .busy(busy), .startDrop(startDrop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: taps, window, running sum, rows done, and a coarse timeline phase
    // (0 idle, 1..3 the three MAC cycles, 4 result presented).
    int m_w   [3];
    int m_win [3];
    int m_acc;
    int m_rows;
    int m_phase;
    logic m_drop;

    function automatic logic [15:0] m_fmt(input int a);
`ifdef PE_SAT_EN
        if (a > 32767)       return 16'h7fff;
        else if (a < -32768) return 16'h8000;
        else                 return a[15:0];
`else
        return a[15:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_w[k]   = 0;
            m_win[k] = 0;
        end
        m_acc = 0; m_rows = 0; m_phase = 0; m_drop = 1'b0;
    endtask

    // One clock cycle with the given inputs; model advanced, then every output checked.
    task automatic cyc(input logic [2:0] sel, input logic rd, input logic st,
                       input logic rdy, input logic [7:0] d);
        int row;
        filtSel = sel; peRead = rd; peStart = st; resReady = rdy; dataIn = d;
        m_drop = st && (m_phase != 0);
        if (m_phase == 0 && st) begin
            row = 0;
            for (int k = 0; k < 3; k++) row += m_win[k] * m_w[k];
            m_acc += row;
            m_rows++;
            m_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            m_phase++;
        end else if (m_phase == 3) begin
            m_phase = (m_rows == ROWS) ? 4 : 0;
        end else if (m_phase == 4 && rdy) begin
            m_acc = 0; m_rows = 0; m_phase = 0;
        end
        for (int k = 0; k < 3; k++) if (sel[k]) m_w[k] = int'($signed(d));
        if (rd) begin
            m_win[2] = m_win[1];
            m_win[1] = m_win[0];
            m_win[0] = int'(d);
        end
        @(posedge clk);
        #1;
        filtSel = 3'd0; peRead = 1'b0; peStart = 1'b0; resReady = 1'b0; dataIn = 8'd0;
        chk("resValid", {31'd0, resValid}, {31'd0, m_phase == 4});
        chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
        chk("startDrop", {31'd0, startDrop}, {31'd0, m_drop});
        if (m_phase == 4) chk("result", {16'd0, result}, {16'd0, m_fmt(m_acc)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic run_row();
        cyc(3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(3);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        for (int i = 0; i < n; i++) begin
            filtSel = 3'($urandom); peRead = 1'($urandom); peStart = 1'($urandom);
            resReady = 1'($urandom); dataIn = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_resValid", {31'd0, resValid}, 32'd0);
            chk("rst_result", {16'd0, result}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_startDrop", {31'd0, startDrop}, 32'd0);
        end
        RST = 1'b0;
        filtSel = 3'd0; peRead = 1'b0; peStart = 1'b0; resReady = 1'b0; dataIn = 8'd0;
        model_reset();
    endtask

    task automatic load_basic();
        cyc(3'b001, 1'b0, 1'b0, 1'b0, 8'd1);
        cyc(3'b010, 1'b0, 1'b0, 1'b0, 8'd2);
        cyc(3'b100, 1'b0, 1'b0, 1'b0, 8'd3);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'd10);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'd20);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'd30);
    endtask

    initial begin
        model_reset();
        do_reset(3);
        idle(2);

        // Three rows of 100 each, then backpressure and handshake.
        load_basic();
        run_row(); run_row(); run_row();
        chk("acc300", {16'd0, result}, {16'd0, m_fmt(300)});
        idle(5);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        idle(1);

        // Pixel shift during MAC0, start dropped in MAC1, then a start dropped in OUT.
        cyc(3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        cyc(3'd0, 1'b1, 1'b0, 1'b0, 8'd99);
        cyc(3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(1);
        run_row(); run_row();
        cyc(3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(1);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        idle(1);

        // Saturation corner: all weights -128, all pixels 255.
        cyc(3'b111, 1'b0, 1'b0, 1'b0, 8'h80);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'hff);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'hff);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 8'hff);
        run_row(); run_row(); run_row();
`ifdef PE_SAT_EN
        chk("sat_result", {16'd0, result}, 32'h0000_8000);
`else
        chk("wrap_result", {16'd0, result}, 32'h0000_8480);
`endif
        idle(2);
        cyc(3'd0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Reset while in MAC1 aborts the row; fresh rows afterwards start from zero.
        load_basic();
        run_row();
        cyc(3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(1);
        do_reset(2);
        idle(2);
        load_basic();
        run_row(); run_row(); run_row();
        chk("post_rst300", {16'd0, result}, {16'd0, m_fmt(300)});
        cyc(3'd0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(3) == 0) ? 3'($urandom) : 3'd0,
                ($urandom_range(2) == 0),
                ($urandom_range(3) == 0),
                ($urandom_range(2) == 0),
                8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
